// File: rtl/pipeline_control.sv
// Hazard and stall sequencer for the 5-stage pipeline: drives stage-register write
// enables, synchronous flushes and the PC enable for branch, load-use and mult/div hazards.
module pipeline_control #(
  parameter int MD_TIMEOUT = 64,
  parameter int STALL_W    = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [4:0]         fd_rs,
  input  logic [4:0]         fd_rt,
  input  logic               fd_uses_rt,
  input  logic               dx_is_lw,
  input  logic [4:0]         dx_rd,
  input  logic               x_branch_taken,
  input  logic               x_is_md,
  input  logic               md_ready,
  output logic               pc_w_en,
  output logic               fd_w_en,
  output logic               dx_w_en,
  output logic               xm_w_en,
  output logic               mw_w_en,
  output logic               fd_flush,
  output logic               dx_flush,
  output logic               xm_flush,
  output logic               md_start,
  output logic               md_timeout,
  output logic [STALL_W-1:0] stall_count,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_START = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

  localparam int CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             load_use;

  assign state_dbg = state;

  assign load_use = dx_is_lw && (dx_rd != 5'd0) &&
                    ((dx_rd == fd_rs) || (fd_uses_rt && (dx_rd == fd_rt)));

  // Mult/div handshake: md_start is a one-cycle request issued from RUN; the unit
  // answers with md_ready for exactly the cycle its result is valid, and the X/M
  // register captures it in that same cycle. No back-pressure exists on either side.
  always_comb begin
    pc_w_en    = 1'b1;
    fd_w_en    = 1'b1;
    dx_w_en    = 1'b1;
    xm_w_en    = 1'b1;
    mw_w_en    = 1'b1;
    fd_flush   = 1'b0;
    dx_flush   = 1'b0;
    xm_flush   = 1'b0;
    md_start   = 1'b0;
    md_timeout = 1'b0;
    next_state = state;

    case (state)
      RUN: begin
        if (x_branch_taken) begin
          fd_flush = 1'b1;
          dx_flush = 1'b1;
        end else if (x_is_md) begin
          md_start   = 1'b1;
          pc_w_en    = 1'b0;
          fd_w_en    = 1'b0;
          dx_w_en    = 1'b0;
          xm_flush   = 1'b1;
          next_state = MD_START;
        end else if (load_use) begin
          pc_w_en  = 1'b0;
          fd_w_en  = 1'b0;
          dx_flush = 1'b1;
        end
      end
      MD_START: begin
        pc_w_en    = 1'b0;
        fd_w_en    = 1'b0;
        dx_w_en    = 1'b0;
        xm_flush   = 1'b1;
        next_state = MD_WAIT;
      end
      MD_WAIT: begin
        if (md_ready) begin
          next_state = RUN;
        end else if (wait_cnt == CNT_LAST) begin
          // Forced release: the pipeline proceeds as if the result had arrived.
          md_timeout = 1'b1;
          next_state = RUN;
        end else begin
          pc_w_en  = 1'b0;
          fd_w_en  = 1'b0;
          dx_w_en  = 1'b0;
          xm_flush = 1'b1;
        end
      end
      default: next_state = RUN;
    endcase

    if (reset) begin
      pc_w_en    = 1'b1;
      fd_w_en    = 1'b1;
      dx_w_en    = 1'b1;
      xm_w_en    = 1'b1;
      mw_w_en    = 1'b1;
      fd_flush   = 1'b1;
      dx_flush   = 1'b1;
      xm_flush   = 1'b1;
      md_start   = 1'b0;
      md_timeout = 1'b0;
      next_state = RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_count <= '0;
    end else begin
      state <= next_state;
      if (state == MD_WAIT && next_state == MD_WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (!pc_w_en && (stall_count != {STALL_W{1'b1}})) begin
        stall_count <= stall_count + STALL_W'(1);
      end
    end
  end

endmodule
